// File: rtl/ram_loader.sv
// ram_loader: streams bytes from a valid/ready source into consecutive RAM
// addresses starting at a programmable base. An optional readback pass
// compares every written word against a shadow copy. The RAM is idle whenever
// the loader is idle.
// Ports: clk/reset; start, base_addr, length and verify_en set up a session.
// in_data/in_valid/in_ready form the byte stream. ram_* drive the RAM port and
// ram_data_out returns read data. busy, done, error and error_addr report status.
// All outputs come straight from registers.
module ram_loader #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  verify_en,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_write_enable,
  output logic                  ram_read_enable,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] error_addr
);

  typedef enum logic [1:0] {IDLE, WRITE, VERIFY, FINISH} state_t;

  state_t                state, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic                  ver_q, ver_d;
  // Byte index during WRITE, then reused as the readback index during VERIFY.
  logic [ADDR_WIDTH:0]   count, count_d, count_inc;
  logic                  in_ready_d, we_d, re_d, done_d, err_d;
  logic [ADDR_WIDTH-1:0] addr_d, eaddr_d;
  logic [DATA_WIDTH-1:0] din_d;
  logic                  hs;

  logic [DATA_WIDTH-1:0] shadow [DEPTH];

  assign hs        = in_valid & in_ready;
  assign count_inc = count + 1'b1;

  // The shadow copy holds data only. Reset does not need to clear it because
  // it is read only after a session has written it.
  always_ff @(posedge clk) begin
    if (state == WRITE && hs)
      shadow[count[ADDR_WIDTH-1:0]] <= in_data;
  end

  always_comb begin
    state_d    = state;
    base_d     = base_q;
    len_d      = len_q;
    ver_d      = ver_q;
    count_d    = count;
    in_ready_d = 1'b0;
    we_d       = 1'b0;
    re_d       = 1'b0;
    addr_d     = ram_address;
    din_d      = ram_data_in;
    done_d     = 1'b0;
    err_d      = error;
    eaddr_d    = error_addr;
    unique case (state)
      IDLE: begin
        if (start) begin
          base_d  = base_addr;
          len_d   = length;
          ver_d   = verify_en;
          count_d = '0;
          err_d   = 1'b0;
          eaddr_d = '0;
          if (length == '0) begin
            state_d = FINISH;
            done_d  = 1'b1;
          end else begin
            state_d    = WRITE;
            in_ready_d = 1'b1;
          end
        end
      end
      WRITE: begin
        if (hs) begin
          we_d       = 1'b1;
          addr_d     = base_q + count[ADDR_WIDTH-1:0];
          din_d      = in_data;
          count_d    = count_inc;
          in_ready_d = (count_inc < len_q);
        end else if (count == len_q) begin
          // The final strobe is on the bus this cycle, so the next cycle
          // is either the first read or the done pulse.
          if (ver_q) begin
            state_d = VERIFY;
            re_d    = 1'b1;
            addr_d  = base_q;
            count_d = '0;
          end else begin
            state_d = FINISH;
            done_d  = 1'b1;
          end
        end else begin
          in_ready_d = 1'b1;
        end
      end
      VERIFY: begin
        if (ram_data_out != shadow[count[ADDR_WIDTH-1:0]]) begin
          err_d   = 1'b1;
          eaddr_d = ram_address;
          state_d = FINISH;
          done_d  = 1'b1;
        end else if (count_inc == len_q) begin
          state_d = FINISH;
          done_d  = 1'b1;
        end else begin
          count_d = count_inc;
          re_d    = 1'b1;
          addr_d  = base_q + count[ADDR_WIDTH-1:0] + 1'b1;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      base_q           <= '0;
      len_q            <= '0;
      ver_q            <= 1'b0;
      count            <= '0;
      in_ready         <= 1'b0;
      ram_write_enable <= 1'b0;
      ram_read_enable  <= 1'b0;
      ram_address      <= '0;
      ram_data_in      <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
      error_addr       <= '0;
    end else begin
      state            <= state_d;
      base_q           <= base_d;
      len_q            <= len_d;
      ver_q            <= ver_d;
      count            <= count_d;
      in_ready         <= in_ready_d;
      ram_write_enable <= we_d;
      ram_read_enable  <= re_d;
      ram_address      <= addr_d;
      ram_data_in      <= din_d;
      busy             <= (state_d != IDLE);
      done             <= done_d;
      error            <= err_d;
      error_addr       <= eaddr_d;
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
module tb_ram_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] base_addr = '0;
  logic [4:0] length = '0;
  logic       verify_en = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] ram_address;
  logic [7:0] ram_data_in;
  logic       ram_write_enable;
  logic       ram_read_enable;
  logic [7:0] ram_data_out;
  logic       busy, done, error;
  logic [3:0] error_addr;

  ram_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .DEPTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .length(length), .verify_en(verify_en), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .ram_address(ram_address),
    .ram_data_in(ram_data_in), .ram_write_enable(ram_write_enable),
    .ram_read_enable(ram_read_enable), .ram_data_out(ram_data_out),
    .busy(busy), .done(done), .error(error), .error_addr(error_addr)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Model RAM with an optional stuck-at-zero read fault.
  logic [7:0] mem [16];
  logic       fault_en = 1'b0;
  logic [3:0] fault_addr = '0;

  always @(posedge clk)
    if (ram_write_enable) mem[ram_address] <= ram_data_in;

  always_comb begin
    ram_data_out = 8'h00;
    if (ram_read_enable)
      ram_data_out = (fault_en && ram_address == fault_addr) ? 8'h00 : mem[ram_address];
  end

  // Scoreboards: {addr,data} expected writes, addr expected reads.
  logic [11:0] wq[$];
  logic [3:0]  rq[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (ram_write_enable && ram_read_enable) check("we_re_excl", 1, 0);
      if (ram_write_enable) begin
        if (wq.size() == 0) check("wr_unexpected", {ram_address, ram_data_in}, 0);
        else begin
          logic [11:0] e;
          e = wq.pop_front();
          check("wr_addr", ram_address, e[11:8]);
          check("wr_data", ram_data_in, e[7:0]);
        end
      end
      if (ram_read_enable) begin
        if (rq.size() == 0) check("rd_unexpected", ram_address, 0);
        else begin
          logic [3:0] a;
          a = rq.pop_front();
          check("rd_addr", ram_address, a);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic do_start(input logic [3:0] b, input logic [4:0] l, input logic v);
    start = 1'b1; base_addr = b; length = l; verify_en = v;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send(input logic [7:0] d, input logic [3:0] a);
    int t;
    t = 0;
    in_valid = 1'b1; in_data = d;
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    if (!in_ready) begin
      check("send_timeout", 0, 1);
    end else begin
      wq.push_back({a, d});
      @(negedge clk);
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 100) begin @(negedge clk); n++; end
    if (!done) check("done_timeout", 0, 1);
  endtask

  int n;
  logic [7:0] wrap_bytes [4];

  initial begin
    wrap_bytes[0] = 8'hA1; wrap_bytes[1] = 8'hB2;
    wrap_bytes[2] = 8'hC3; wrap_bytes[3] = 8'hD4;

    // Reset state
    #12;
    check("rst_busy", busy, 0);
    check("rst_ready", in_ready, 0);
    check("rst_we", ram_write_enable, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset mid-session after three bytes
    do_start(4'd0, 5'd8, 1'b0);
    check("start_busy", busy, 1);
    check("start_ready", in_ready, 1);
    for (int i = 0; i < 3; i++) send(8'h40 + 8'(i), 4'(i));
    #2 reset = 1'b1; in_valid = 1'b0;
    #1;
    check("mid_rst_outs", {busy, in_ready, ram_write_enable, ram_read_enable, done, error}, 0);
    check("mid_rst_addr", {ram_address, ram_data_in, error_addr}, 0);
    @(negedge clk);
    reset = 1'b0;
    wq.delete();
    @(negedge clk);
    check("post_rst_idle", busy, 0);

    // Basic load 0..15
    do_start(4'd0, 5'd16, 1'b0);
    for (int i = 0; i < 16; i++) send(8'h10 + 8'(i), 4'(i));
    in_valid = 1'b0;
    check("basic_ready_drop", in_ready, 0);
    wait_done(n);
    check("basic_done_lat", n, 1);
    check("basic_err", error, 0);
    @(negedge clk);
    check("basic_done_pulse", done, 0);
    check("basic_busy_off", busy, 0);

    // Wrap and stall, with an ignored start in the middle
    do_start(4'd14, 5'd4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send(wrap_bytes[i], 4'(14 + i));
      in_valid = 1'b0;
      if (i < 3) begin
        check("stall_ready", in_ready, 1);
        if (i == 1) begin start = 1'b1; base_addr = 4'd7; length = 5'd2; end
        @(negedge clk);
        start = 1'b0;
      end
    end
    check("wrap_ready_drop", in_ready, 0);
    wait_done(n);
    check("wrap_done_lat", n, 1);
    @(negedge clk);

    // Verify pass: base 3, five bytes
    do_start(4'd3, 5'd5, 1'b1);
    for (int i = 0; i < 5; i++) rq.push_back(4'(3 + i));
    for (int i = 0; i < 5; i++) send(8'hC0 + 8'(i), 4'(3 + i));
    in_valid = 1'b0;
    wait_done(n);
    check("vpass_done_lat", n, 6);
    check("vpass_err", error, 0);
    @(negedge clk);

    // Verify fail: address 5 reads back zero
    fault_en = 1'b1; fault_addr = 4'd5;
    do_start(4'd3, 5'd5, 1'b1);
    for (int i = 0; i < 3; i++) rq.push_back(4'(3 + i));
    for (int i = 0; i < 5; i++) send(8'h55 + 8'(i * 17), 4'(3 + i));
    in_valid = 1'b0;
    wait_done(n);
    check("vfail_done_lat", n, 4);
    check("vfail_err", error, 1);
    check("vfail_err_addr", error_addr, 5);
    @(negedge clk);
    check("vfail_err_sticky", error, 1);
    fault_en = 1'b0;

    // length = 0: done right after start, error cleared, no strobes
    do_start(4'd9, 5'd0, 1'b1);
    check("len0_done", done, 1);
    check("len0_err_clr", error, 0);
    @(negedge clk);
    check("len0_done_pulse", done, 0);
    @(negedge clk);
    check("len0_idle", busy, 0);

    check("wq_empty", wq.size(), 0);
    check("rq_empty", rq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ram_loader.md
# ram_loader

Sequential writer for the SAP-1 16×8 program/data RAM: accepts a stream of bytes over a valid/ready handshake and writes them to consecutive RAM addresses, starting at a programmable base address. Optionally reads every written location back and compares it against an internal shadow copy. The block sits between the front-panel/host program source and the RAM write port, and releases the RAM to the CPU side when not busy.

## Interface

Parameters:
- ADDR_WIDTH, 4, RAM address width
- DATA_WIDTH, 8, RAM word width
- DEPTH, 16, number of RAM words (2**ADDR_WIDTH)

Ports:
- clk  input  1  system clock; all state changes on its rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  sampled in IDLE only; begins a load session
- base_addr  input  ADDR_WIDTH  first RAM address written; sampled with start
- length  input  ADDR_WIDTH+1  byte count, 0..DEPTH; sampled with start
- verify_en  input  1  enables the readback pass; sampled with start
- in_data  input  DATA_WIDTH  byte to write
- in_valid  input  1  in_data valid
- in_ready  output  1  loader accepts in_data this cycle
- ram_address  output  ADDR_WIDTH  RAM address
- ram_data_in  output  DATA_WIDTH  RAM write data
- ram_write_enable  output  1  one-cycle RAM write strobe
- ram_read_enable  output  1  RAM read enable (verify pass only)
- ram_data_out  input  DATA_WIDTH  RAM read data; combinational from ram_address while ram_read_enable=1
- busy  output  1  session in progress (state ≠ IDLE)
- done  output  1  one-cycle pulse at session end
- error  output  1  verify mismatch; sticky until next accepted start
- error_addr  output  ADDR_WIDTH  address of the first mismatch

## Operation

- States: IDLE, WRITE, VERIFY, FINISH.
- IDLE: in_ready=0, both RAM enables 0. start=1 latches base_addr, length, verify_en, clears count, error and error_addr. The next state is WRITE, or FINISH if length=0.
- WRITE: in_ready=1 while count<length. Each handshake (in_valid&in_ready) stores in_data into shadow[count]. On the next cycle it drives ram_write_enable=1, ram_address=(base+count) mod DEPTH and ram_data_in=in_data. count then increments.
- Back-to-back handshakes give one write per cycle. in_valid=0 stalls without side effects.
- After the handshake that makes count=length, in_ready=0 next cycle. Once the final write strobe has issued, the next state is VERIFY if verify_en=1, else FINISH.
- VERIFY: for k=0..length-1, one cycle each: ram_read_enable=1 and ram_address=(base+k) mod DEPTH. ram_data_out is compared with shadow[k] in the same cycle.
- On the first mismatch: error=1, error_addr=that address, go to FINISH (remaining reads skipped).
- If all words match, go to FINISH after k=length-1.
- FINISH: done=1 for one cycle, then IDLE.
- Address arithmetic is modulo DEPTH. Example: base=14, length=4 writes 14, 15, 0, 1.
- length>DEPTH cannot be encoded. length=DEPTH writes every word exactly once.
- start while busy=1 is ignored. Parameters latched at start are not re-sampled mid-session.
- ram_write_enable and ram_read_enable are never high in the same cycle.

## Timing

- Reset (asynchronous, immediate) drives: state=IDLE, in_ready=0, ram_write_enable=0, ram_read_enable=0, ram_address=0, ram_data_in=0, busy=0, done=0, error=0, error_addr=0, count=0. Any in-flight write is dropped.
- All outputs are registered; none depend combinationally on inputs.
- start at edge E0: busy=1 and in_ready=1 from E0+1.
- Handshake at edge En: write strobe is high during cycle En+1.
- No verify, L back-to-back bytes starting at E1: the last write strobe is in cycle E(L+1). done is high in cycle E(L+2), busy=0 from E(L+3).
- With verify (no mismatch): the L read cycles follow the last write strobe directly, then one done cycle.
- length=0: done at E0+1, no RAM strobes.
- error and error_addr are valid from the done cycle and hold until the next accepted start.

## Test plan

- Reset mid-session: assert reset during WRITE after 3 bytes -> outputs zero immediately; after release, state is IDLE and the next start behaves normally.
- Basic load: base=0, length=16, verify_en=0, bytes 0x10..0x1F back-to-back -> 16 write strobes, address 0..15 with data 0x10..0x1F, done exactly 1 cycle, error=0.
- Wrap and stall: base=14, length=4, bytes A1, B2, C3, D4 with in_valid low every other cycle -> writes at addresses 14, 15, 0, 1. No strobe occurs in stall cycles and in_ready stays 1 until the 4th handshake.
- Verify pass: load 5 bytes at base=3 with verify_en=1 into a model RAM -> 5 read cycles at addresses 3..7, error=0, done after the last read.
- Verify fail: model RAM forces address 5 to read 0x00 instead of 0x77 (base=3, length=5) -> reads stop at address 5; error=1, error_addr=5, done the next cycle.
- Edge starts: length=0 -> done at E0+1, no strobes. start pulsed during WRITE -> ignored; length and base unchanged.
